// File: rtl/lab_vector_sweeper.sv
// Purpose : sweeps every input code of a small lab DUT, checks resp against a truth table.
// Latency : each code is held DWELL cycles; start edge to done edge is DWELL*2^N_IN cycles.
// Backpr. : none; start is ignored while busy, and exp_table must stay static during a sweep.
module lab_vector_sweeper #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 2,
   parameter int DWELL  = 10,
   parameter int INVERT = 1,
   parameter int GRAY   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [N_OUT*(2**N_IN)-1:0]   exp_table,
   input  logic [N_OUT-1:0]             resp,
   output logic [N_IN-1:0]              stim,
   output logic [N_IN-1:0]              code,
   output logic                         busy,
   output logic                         done,
   output logic [N_IN:0]                err_count,
   output logic                         first_err_valid,
   output logic [N_IN-1:0]              first_err_code
);

   // The dwell counter needs at least one bit even when DWELL is 1.
   localparam int                DC_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DWELL - 1);
   localparam logic [N_IN-1:0]   I_LAST  = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Step index to logical code: binary or reflected Gray order.
   function automatic logic [N_IN-1:0] to_code(input logic [N_IN-1:0] idx);
      return (GRAY != 0) ? (idx ^ (idx >> 1)) : idx;
   endfunction

   // Logical code to the physical value on the DUT input pins.
   function automatic logic [N_IN-1:0] to_stim(input logic [N_IN-1:0] c);
      return (INVERT != 0) ? ~c : c;
   endfunction

   state_t            state, state_n;
   logic [N_IN-1:0]   idx_q, idx_n;
   logic [DC_W-1:0]   dc_q, dc_n;
   logic [N_IN-1:0]   code_q, code_n;
   logic [N_IN-1:0]   stim_q, stim_n;
   logic [N_IN:0]     err_q, err_n;
   logic              fv_q, fv_n;
   logic [N_IN-1:0]   fc_q, fc_n;

   logic [N_OUT-1:0]  exp_entry;
   logic              sample;
   logic              mismatch;
   logic [N_IN-1:0]   code_next_step;

   // Expected response for the code currently on the pins.
   assign exp_entry = exp_table[int'(code_q) * N_OUT +: N_OUT];

   // Compare point is the last cycle of each dwell; X on resp counts as a mismatch.
   assign sample         = (state == S_RUN) && (dc_q == DC_LAST);
   assign mismatch       = sample && (resp !== exp_entry);
   assign code_next_step = to_code(idx_q + 1'b1);

   // Next-state and datapath update; every target defaults to holding its value.
   always_comb begin
      state_n = state;
      idx_n   = idx_q;
      dc_n    = dc_q;
      code_n  = code_q;
      stim_n  = stim_q;
      err_n   = err_q;
      fv_n    = fv_q;
      fc_n    = fc_q;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_RUN;
               idx_n   = '0;
               dc_n    = '0;
               code_n  = to_code('0);
               stim_n  = to_stim(to_code('0));
               err_n   = '0;
               fv_n    = 1'b0;
               fc_n    = '0;
            end
         end

         S_RUN: begin
            dc_n = dc_q + 1'b1;
            if (mismatch) begin
               err_n = err_q + 1'b1;
               if (!fv_q) begin
                  fv_n = 1'b1;
                  fc_n = code_q;
               end
            end
            if (sample) begin
               if (idx_q == I_LAST) begin
                  // Last code checked: park on it, keep the counter where it is.
                  state_n = S_DONE;
                  dc_n    = dc_q;
               end else begin
                  idx_n  = idx_q + 1'b1;
                  dc_n   = '0;
                  code_n = code_next_step;
                  stim_n = to_stim(code_next_step);
               end
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any sweep in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx_q  <= '0;
         dc_q   <= '0;
         code_q <= '0;
         stim_q <= to_stim('0);
         err_q  <= '0;
         fv_q   <= 1'b0;
         fc_q   <= '0;
      end else begin
         state  <= state_n;
         idx_q  <= idx_n;
         dc_q   <= dc_n;
         code_q <= code_n;
         stim_q <= stim_n;
         err_q  <= err_n;
         fv_q   <= fv_n;
         fc_q   <= fc_n;
      end
   end

   assign stim            = stim_q;
   assign code            = code_q;
   assign busy            = (state == S_RUN);
   assign done            = (state == S_DONE);
   assign err_count       = err_q;
   assign first_err_valid = fv_q;
   assign first_err_code  = fc_q;

endmodule

// File: tb/tb_lab_vector_sweeper.sv
// Bench for lab_vector_sweeper: three configurations swept against a small lab
// function (X = c0&c1, Y = c2|c3), with table vectors, a mid-sweep reset and
// randomized table corruption checked against a sweep-order reference model.
module tb_lab_vector_sweeper;

   logic        clk;
   logic        rst_n;
   logic        start_s   [3];
   logic [31:0] table_s   [3];
   logic [1:0]  resp_s    [3];
   logic [3:0]  stim_o    [3];
   logic [3:0]  code_o    [3];
   logic        busy_o    [3];
   logic        done_o    [3];
   logic [4:0]  ec_o      [3];
   logic        fv_o      [3];
   logic [3:0]  fc_o      [3];

   int total;
   int bad;

   // Lab function on the logical code.
   function automatic logic [1:0] lab_fn(input logic [3:0] c);
      return {c[2] | c[3], c[0] & c[1]};
   endfunction

   // Lab DUTs: instance 0 wired active-high, instances 1 and 2 active-low.
   assign resp_s[0] = lab_fn(stim_o[0]);
   assign resp_s[1] = lab_fn(~stim_o[1]);
   assign resp_s[2] = lab_fn(~stim_o[2]);

   lab_vector_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(3),  .INVERT(0), .GRAY(0)) u_bin (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .exp_table(table_s[0]), .resp(resp_s[0]),
      .stim(stim_o[0]), .code(code_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .err_count(ec_o[0]), .first_err_valid(fv_o[0]), .first_err_code(fc_o[0]));

   lab_vector_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(10), .INVERT(1), .GRAY(0)) u_inv (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .exp_table(table_s[1]), .resp(resp_s[1]),
      .stim(stim_o[1]), .code(code_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .err_count(ec_o[1]), .first_err_valid(fv_o[1]), .first_err_code(fc_o[1]));

   lab_vector_sweeper #(.N_IN(4), .N_OUT(2), .DWELL(1),  .INVERT(1), .GRAY(1)) u_gray (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .exp_table(table_s[2]), .resp(resp_s[2]),
      .stim(stim_o[2]), .code(code_o[2]), .busy(busy_o[2]), .done(done_o[2]),
      .err_count(ec_o[2]), .first_err_valid(fv_o[2]), .first_err_code(fc_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dwell_of(input int sel);
      case (sel)
         0: return 3;
         1: return 10;
         default: return 1;
      endcase
   endfunction

   function automatic bit inv_of(input int sel);
      return (sel != 0);
   endfunction

   function automatic bit gray_of(input int sel);
      return (sel == 2);
   endfunction

   // Logical code presented at sweep step idx.
   function automatic logic [3:0] code_at(input int sel, input int idx);
      logic [3:0] i;
      i = idx[3:0];
      return gray_of(sel) ? (i ^ (i >> 1)) : i;
   endfunction

   function automatic logic [3:0] stim_of(input int sel, input logic [3:0] c);
      return inv_of(sel) ? ~c : c;
   endfunction

   // Correct truth table with the entries flagged in mask corrupted.
   function automatic logic [31:0] make_table(input logic [15:0] mask);
      logic [31:0] t;
      logic [3:0]  cv;
      t = '0;
      for (int c = 0; c < 16; c++) begin
         cv = c[3:0];
         t[c*2 +: 2] = lab_fn(cv) ^ {1'b0, mask[c]};
      end
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full sweep: start-edge clears, per-cycle code/stim sequence, exact length, hold after done.
   task automatic run_sweep(input int sel, input logic [15:0] mask, input bit extra);
      int         k;
      int         dw;
      int         seq_bad;
      int         gray_bad;
      bit         pulsed;
      logic [3:0] exp_c;
      logic [3:0] prev_stim;
      dw = dwell_of(sel);
      table_s[sel] = make_table(mask);
      start_s[sel] = 1'b1;
      step();
      start_s[sel] = 1'b0;
      check("start_busy", busy_o[sel], 1);
      check("start_done_clear", done_o[sel], 0);
      check("start_err_clear", ec_o[sel], 0);
      check("start_fv_clear", fv_o[sel], 0);
      k = 0; seq_bad = 0; gray_bad = 0; pulsed = 0;
      prev_stim = stim_o[sel];
      while (done_o[sel] !== 1'b1 && k < dw*16 + 40) begin
         exp_c = code_at(sel, k / dw);
         if (code_o[sel] !== exp_c || stim_o[sel] !== stim_of(sel, exp_c) || busy_o[sel] !== 1'b1)
            seq_bad++;
         if (k > 0 && stim_o[sel] !== prev_stim && $countones(stim_o[sel] ^ prev_stim) != 1)
            gray_bad++;
         prev_stim = stim_o[sel];
         if (extra && !pulsed && code_o[sel] == 4'd3) begin
            start_s[sel] = 1'b1;
            pulsed = 1'b1;
         end
         step();
         start_s[sel] = 1'b0;
         k++;
      end
      check("sweep_len", k, dw*16);
      check("sweep_seq", seq_bad, 0);
      if (gray_of(sel)) check("gray_one_bit", gray_bad, 0);
      check("done_busy_low", busy_o[sel], 0);
      step();
      step();
      check("done_hold", done_o[sel], 1);
      check("done_code_hold", code_o[sel], code_at(sel, 15));
   endtask

   typedef struct {
      int          sel;
      logic [15:0] mask;
      bit          extra;
      int          exp_err;
      bit          exp_fv;
      logic [3:0]  exp_fc;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int         n_err;
      bit         m_fv;
      logic [3:0] m_fc;
      logic [3:0] c;
      int         sel;
      logic [15:0] mask;
      int         k;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         start_s[s] = 1'b0;
         table_s[s] = make_table(16'h0000);
      end

      vecs[0] = '{0, 16'h0000, 1'b0, 0,  1'b0, 4'd0};
      vecs[1] = '{0, 16'h1020, 1'b1, 2,  1'b1, 4'd5};
      vecs[2] = '{1, 16'h0000, 1'b0, 0,  1'b0, 4'd0};
      vecs[3] = '{2, 16'h0000, 1'b0, 0,  1'b0, 4'd0};
      vecs[4] = '{2, 16'h2100, 1'b0, 2,  1'b1, 4'd13};
      vecs[5] = '{0, 16'h2100, 1'b0, 2,  1'b1, 4'd8};
      vecs[6] = '{0, 16'hFFFF, 1'b0, 16, 1'b1, 4'd0};
      vecs[7] = '{0, 16'h0000, 1'b1, 0,  1'b0, 4'd0};
      vecs[8] = '{1, 16'h0001, 1'b0, 1,  1'b1, 4'd0};
      vecs[9] = '{1, 16'h8000, 1'b1, 1,  1'b1, 4'd15};

      step();
      step();
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         check("rst_busy", busy_o[s], 0);
         check("rst_done", done_o[s], 0);
         check("rst_err", ec_o[s], 0);
         check("rst_fv", fv_o[s], 0);
         check("rst_fc", fc_o[s], 0);
         check("rst_code", code_o[s], 0);
         check("rst_stim", stim_o[s], inv_of(s) ? 4'hF : 4'h0);
      end

      // Table-driven sweeps with hand-derived results.
      for (int v = 0; v < 10; v++) begin
         run_sweep(vecs[v].sel, vecs[v].mask, vecs[v].extra);
         check("vec_err_count", ec_o[vecs[v].sel], vecs[v].exp_err);
         check("vec_first_valid", fv_o[vecs[v].sel], vecs[v].exp_fv);
         check("vec_first_code", fc_o[vecs[v].sel], vecs[v].exp_fc);
      end

      // Mid-sweep reset at code 0111 after one error at code 0010.
      table_s[0] = make_table(16'h0004);
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      k = 0;
      while (code_o[0] !== 4'd7 && k < 200) begin
         step();
         k++;
      end
      check("midrst_reach_7", code_o[0], 7);
      check("midrst_err_before", ec_o[0], 1);
      check("midrst_busy_before", busy_o[0], 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_busy", busy_o[0], 0);
      check("midrst_done", done_o[0], 0);
      check("midrst_err", ec_o[0], 0);
      check("midrst_fv", fv_o[0], 0);
      check("midrst_stim", stim_o[0], 0);
      check("midrst_code", code_o[0], 0);
      step();
      step();
      check("midrst_stays_idle", busy_o[0], 0);

      // Randomized corruption checked against a sweep-order model.
      for (int r = 0; r < 12; r++) begin
         sel = $urandom_range(0, 2);
         if (r % 3 == 0)
            mask = 16'h0000;
         else if (r % 3 == 1)
            mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
         else
            mask = 16'($urandom);
         n_err = 0; m_fv = 0; m_fc = 0;
         for (int i = 0; i < 16; i++) begin
            c = code_at(sel, i);
            if (mask[c]) begin
               n_err++;
               if (!m_fv) begin
                  m_fv = 1'b1;
                  m_fc = c;
               end
            end
         end
         run_sweep(sel, mask, r[0]);
         check("rnd_err_count", ec_o[sel], n_err);
         check("rnd_first_valid", fv_o[sel], m_fv);
         check("rnd_first_code", fc_o[sel], m_fc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
